// File: rtl/windowed_multicycle_datapath.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB datapath for the 16-bit teaching CPU,
// with a windowed register file (global R0, banked R1-R3) and a stallable data port.
module windowed_multicycle_datapath #(
  parameter int WIDTH       = 16,
  parameter int PC_W        = 12,
  parameter int NUM_WINDOWS = 4,
  localparam int WW         = $clog2(NUM_WINDOWS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_en,
  input  logic [15:0]      imem_rdata,
  output logic [WIDTH-1:0] dmem_addr,
  output logic             dmem_en,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic [PC_W-1:0]  pc,
  output logic [WW-1:0]    window,
  output logic             halted,
  output logic [31:0]      retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB  = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_ADDI = 4'd4, OP_LOAD = 4'd5, OP_STORE = 4'd6, OP_BEQZ = 4'd7,
    OP_JMP  = 4'd8, OP_WIN  = 4'd9, OP_HALT = 4'd15
  } op_t;

  state_t           r_state, w_next;
  logic [15:0]      r_ir;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [PC_W-1:0]  r_pc;
  logic [WW-1:0]    r_win;
  logic             r_halted;
  logic [31:0]      r_retired;
  logic [WIDTH-1:0] r_r0;
  logic [WIDTH-1:0] r_bank [NUM_WINDOWS][1:3];

  op_t              w_op;
  logic [1:0]       w_rd;
  logic [WIDTH-1:0] w_sx, w_alu, w_rd_val, w_rs_val;
  logic [PC_W-1:0]  w_sx_pc, w_pc_inc, w_jmp;
  logic             w_retire;

  assign w_op = op_t'(r_ir[15:12]);
  assign w_rd = r_ir[11:10];

  always_comb begin
    w_sx     = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
    w_sx_pc  = {{(PC_W-8){r_ir[7]}}, r_ir[7:0]};
    w_pc_inc = r_pc + PC_W'(1);
    // JMP replaces only the low 12 bits; upper PC bits (if PC_W > 12) are kept.
    w_jmp       = r_pc;
    w_jmp[11:0] = r_ir[11:0];
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_ADDI: w_alu = r_a + w_sx;
      default: w_alu = r_b + w_sx;
    endcase
    w_rd_val = (imem_rdata[11:10] == 2'd0) ? r_r0 : r_bank[r_win][imem_rdata[11:10]];
    w_rs_val = (imem_rdata[9:8] == 2'd0)   ? r_r0 : r_bank[r_win][imem_rdata[9:8]];
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: w_next = S_WB;
          OP_LOAD, OP_STORE:                      w_next = S_MEM;
          OP_HALT:                                w_next = S_HALT;
          default: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (w_op == OP_LOAD) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_pc      <= '0;
      r_win     <= '0;
      r_halted  <= 1'b0;
      r_retired <= '0;
      r_r0      <= '0;
      r_bank    <= '{default: '0};
    end else begin
      if (w_retire && r_retired != '1) r_retired <= r_retired + 32'd1;
      case (r_state)
        S_DECODE: begin
          r_ir <= imem_rdata;
          r_a  <= w_rd_val;
          r_b  <= w_rs_val;
        end
        S_EXEC: begin
          case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LOAD, OP_STORE: r_res <= w_alu;
            OP_BEQZ: r_pc <= (r_a == '0) ? w_pc_inc + w_sx_pc : w_pc_inc;
            OP_JMP:  r_pc <= w_jmp;
            OP_WIN: begin
              r_win <= r_ir[WW-1:0];
              r_pc  <= w_pc_inc;
            end
            OP_HALT: r_halted <= 1'b1;
            default: r_pc <= w_pc_inc;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (w_op == OP_LOAD) r_res <= dmem_rdata;
            else                 r_pc  <= w_pc_inc;
          end
        end
        S_WB: begin
          if (w_rd == 2'd0) r_r0 <= r_res;
          else              r_bank[r_win][w_rd] <= r_res;
          r_pc <= w_pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign imem_en    = (r_state == S_FETCH) && !rst;
  assign dmem_en    = (r_state == S_MEM);
  assign dmem_we    = dmem_en && (w_op == OP_STORE);
  assign dmem_addr  = r_res;
  assign dmem_wdata = r_a;
  assign pc         = r_pc;
  assign window     = r_win;
  assign halted     = r_halted;
  assign retired    = r_retired;

endmodule

// File: tb/tb_windowed_multicycle_datapath.sv
// Directed bench for windowed_multicycle_datapath: small programs in a bench-side
// instruction ROM, results observed through stores into a bench-side data memory.
module tb_windowed_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata = '0;
  logic [15:0] dmem_addr;
  logic        dmem_en;
  logic        dmem_we;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ready;
  logic [11:0] pc;
  logic [1:0]  window;
  logic        halted;
  logic [31:0] retired;

  logic [15:0] imem [4096];
  logic [15:0] dmem [256];
  int unsigned stall_cfg = 0;
  int unsigned mem_cyc   = 0;
  int checks = 0;
  int errors = 0;

  windowed_multicycle_datapath #(.WIDTH(16), .PC_W(12), .NUM_WINDOWS(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_en(dmem_en), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .window(window), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= imem[imem_addr];

  // Data port answers after stall_cfg wait cycles of a continuous request.
  assign dmem_ready = dmem_en && (mem_cyc >= stall_cfg);
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  always @(posedge clk) begin
    mem_cyc <= dmem_en ? mem_cyc + 1 : 0;
    if (dmem_en && dmem_ready && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) step(1);
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    // Program A: ALU ops
    clear_imem();
    imem[0] = enc(4'd4, 2'd1, 2'd0, 8'h05);   // ADDI R1,5
    imem[1] = enc(4'd4, 2'd2, 2'd0, 8'hFD);   // ADDI R2,-3
    imem[2] = enc(4'd0, 2'd1, 2'd2, 8'h00);   // ADD R1,R2 -> 2
    imem[3] = enc(4'd6, 2'd1, 2'd0, 8'h20);   // STORE R1,[0x20]
    imem[4] = enc(4'd1, 2'd2, 2'd1, 8'h00);   // SUB R2,R1 -> FFFB
    imem[5] = enc(4'd6, 2'd2, 2'd0, 8'h21);
    imem[6] = enc(4'd3, 2'd1, 2'd2, 8'h00);   // OR R1,R2 -> FFFB
    imem[7] = enc(4'd6, 2'd1, 2'd0, 8'h22);
    rst = 1'b1;
    step(2);
    check("rst_pc", {20'd0, pc}, 32'd0);
    check("rst_window", {30'd0, window}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_imem_en", {31'd0, imem_en}, 32'd0);
    check("rst_dmem_en", {31'd0, dmem_en}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    rst = 1'b0;
    step(12);
    check("alu_retired_c12", retired, 32'd3);
    check("alu_pc_c12", {20'd0, pc}, 32'd3);
    wait_halt("alu_halt", 200);
    check("alu_add", {16'd0, dmem[8'h20]}, 32'h0002);
    check("alu_sub", {16'd0, dmem[8'h21]}, 32'hFFFB);
    check("alu_or", {16'd0, dmem[8'h22]}, 32'hFFFB);
    check("alu_retired", retired, 32'd8);
    check("alu_halt_pc", {20'd0, pc}, 32'd8);

    // Program B: register windows
    clear_imem();
    imem[0]  = enc(4'd4, 2'd1, 2'd0, 8'd7);   // ADDI R1,7 (w0)
    imem[1]  = enc(4'd9, 2'd0, 2'd0, 8'd1);   // WIN 1
    imem[2]  = enc(4'd4, 2'd1, 2'd0, 8'd9);   // ADDI R1,9 (w1)
    imem[3]  = enc(4'd4, 2'd0, 2'd0, 8'd4);   // ADDI R0,4
    imem[4]  = enc(4'd6, 2'd1, 2'd0, 8'h30);  // [0x34] = 9
    imem[5]  = enc(4'd9, 2'd0, 2'd0, 8'd0);   // WIN 0
    imem[6]  = enc(4'd6, 2'd1, 2'd0, 8'h40);  // [0x44] = 7
    imem[7]  = enc(4'd6, 2'd0, 2'd0, 8'h50);  // [0x54] = 4
    imem[8]  = enc(4'd9, 2'd0, 2'd0, 8'd1);   // WIN 1
    imem[9]  = enc(4'd6, 2'd0, 2'd0, 8'h60);  // [0x64] = 4
    do_reset();
    wait_halt("win_halt", 300);
    check("win1_r1", {16'd0, dmem[8'h34]}, 32'd9);
    check("win0_r1", {16'd0, dmem[8'h44]}, 32'd7);
    check("win0_r0", {16'd0, dmem[8'h54]}, 32'd4);
    check("win1_r0", {16'd0, dmem[8'h64]}, 32'd4);
    check("win_final", {30'd0, window}, 32'd1);
    check("win_retired", retired, 32'd10);

    // Program C: memory stall then load-back
    clear_imem();
    imem[0] = enc(4'd4, 2'd2, 2'd0, 8'h10);   // ADDI R2,0x10
    imem[1] = enc(4'd4, 2'd1, 2'd0, 8'h5A);   // ADDI R1,0x5A
    imem[2] = enc(4'd6, 2'd1, 2'd2, 8'h02);   // STORE R1,[R2+2]
    imem[3] = enc(4'd5, 2'd3, 2'd2, 8'h02);   // LOAD R3,[R2+2]
    imem[4] = enc(4'd6, 2'd3, 2'd0, 8'h70);   // STORE R3,[0x70]
    stall_cfg = 3;
    do_reset();
    step(11);
    for (int i = 0; i < 4; i++) begin
      check("stall_en", {31'd0, dmem_en}, 32'd1);
      check("stall_addr", {16'd0, dmem_addr}, 32'h12);
      check("stall_we", {31'd0, dmem_we}, 32'd1);
      check("stall_wdata", {16'd0, dmem_wdata}, 32'h5A);
      step(1);
    end
    check("stall_done_en", {31'd0, dmem_en}, 32'd0);
    check("stall_done_pc", {20'd0, pc}, 32'd3);
    stall_cfg = 0;
    wait_halt("mem_halt", 200);
    check("mem_store", {16'd0, dmem[8'h12]}, 32'h5A);
    check("mem_loadback", {16'd0, dmem[8'h70]}, 32'h5A);
    check("mem_retired", retired, 32'd5);

    // Program D: branch wrap-around
    clear_imem();
    imem[0]     = 16'h8FFF;                    // JMP 0xFFF
    imem[12'hFFF] = enc(4'd7, 2'd3, 2'd0, 8'd1); // BEQZ R3,+1
    imem[1]     = enc(4'd4, 2'd3, 2'd0, 8'd1); // ADDI R3,1
    imem[2]     = 16'h8FFF;
    do_reset();
    step(3);
    check("jmp_pc", {20'd0, pc}, 32'hFFF);
    step(3);
    check("beqz_taken_wrap", {20'd0, pc}, 32'h001);
    step(7);
    check("jmp2_pc", {20'd0, pc}, 32'hFFF);
    step(3);
    check("beqz_not_taken_wrap", {20'd0, pc}, 32'h000);
    check("br_retired", retired, 32'd5);

    // Program E: HALT at pc 4
    clear_imem();
    imem[0] = 16'hA000;
    imem[1] = 16'hB000;
    imem[2] = 16'hC000;
    imem[3] = 16'hE000;
    do_reset();
    step(14);
    check("pre_halt", {31'd0, halted}, 32'd0);
    step(1);
    check("halt_rise", {31'd0, halted}, 32'd1);
    check("halt_pc", {20'd0, pc}, 32'd4);
    check("halt_retired", retired, 32'd4);
    for (int i = 0; i < 20; i++) begin
      check("halt_imem_en", {31'd0, imem_en}, 32'd0);
      step(1);
    end
    check("halt_retired_frozen", retired, 32'd4);
    rst = 1'b1;
    step(1);
    check("halt_rst_pc", {20'd0, pc}, 32'd0);
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    // Program F: reset during a stalled LOAD
    clear_imem();
    imem[0] = enc(4'd5, 2'd1, 2'd0, 8'h20);   // LOAD R1,[0x20] (mem holds 2)
    stall_cfg = 50;
    do_reset();
    step(3);
    check("midmem_en", {31'd0, dmem_en}, 32'd1);
    check("midmem_we", {31'd0, dmem_we}, 32'd0);
    check("midmem_addr", {16'd0, dmem_addr}, 32'h20);
    step(2);
    rst = 1'b1;
    step(1);
    check("midmem_rst_en", {31'd0, dmem_en}, 32'd0);
    check("midmem_rst_pc", {20'd0, pc}, 32'd0);
    imem[0] = enc(4'd6, 2'd1, 2'd0, 8'h22);   // STORE R1,[0x22]
    stall_cfg = 0;
    rst = 1'b0;
    #1;
    check("midmem_fetch_en", {31'd0, imem_en}, 32'd1);
    check("midmem_fetch_addr", {20'd0, imem_addr}, 32'd0);
    wait_halt("midmem_halt", 100);
    check("midmem_rd_unchanged", {16'd0, dmem[8'h22]}, 32'd0);
    check("midmem_retired", retired, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
